// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of loader, instruction-memory and decode-stage signals around the
// instruction fetch controller. The controller uses the master modport; the
// surrounding system (loader, memory, decode) uses the slave modport.
interface instr_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  // phase control
  logic              start_load;
  logic              run;
  // loader word stream
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  // instruction memory byte port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  // decode-stage handshake
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;
  // control-flow redirect
  logic              redir_valid;
  logic [31:0]       redir_pc;
  // status
  logic              busy;
  logic              load_done;
  logic              align_err;

  modport master (
    input  start_load, run,
    input  ld_valid, ld_data, ld_last,
    output ld_ready,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  redir_valid, redir_pc,
    output busy, load_done, align_err
  );

  modport slave (
    output start_load, run,
    output ld_valid, ld_data, ld_last,
    input  ld_ready,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output redir_valid, redir_pc,
    input  busy, load_done, align_err
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller. Owns the single byte port of a big-endian
// byte-addressed instruction memory and time-shares it between a boot-load
// phase (32-bit loader words written one byte per cycle) and a fetch phase
// (four byte reads assembled into an instruction, offered to decode over a
// valid/ready handshake). All outputs are registered, so each transition
// also sets up the memory address/data for the cycle that follows it.
module instr_fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [31:0]       RESET_PC  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_WR,
    FETCH,
    HOLD,
    ERR
  } state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] wAddr_q;
  logic [31:0]       word_q;
  logic              last_q;
  logic [1:0]        k_q;

  logic              ldReady_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic              memWe_q;
  logic [7:0]        memWdata_q;
  logic              instValid_q;
  logic [31:0]       inst_q;
  logic [31:0]       instPc_q;
  logic              busy_q;
  logic              loadDone_q;
  logic              alignErr_q;

  logic [1:0]        kPlus1_d;
  logic [ADDR_W-1:0] wrNextAddr_d;
  logic [ADDR_W-1:0] fetchNextAddr_d;
  logic [31:0]       pcPlus4_d;
  logic [7:0]        wrNextByte_d;

  // Next byte address / byte lane for the step after the current k, and the sequential pc.
  always_comb begin
    kPlus1_d        = k_q + 2'd1;
    wrNextAddr_d    = wAddr_q + ADDR_W'(kPlus1_d);
    fetchNextAddr_d = pc_q[ADDR_W-1:0] + ADDR_W'(kPlus1_d);
    pcPlus4_d       = pc_q + 32'd4;
    case (kPlus1_d)
      2'd1:    wrNextByte_d = word_q[23:16];
      2'd2:    wrNextByte_d = word_q[15:8];
      2'd3:    wrNextByte_d = word_q[7:0];
      default: wrNextByte_d = word_q[31:24];
    endcase
  end

  // Sequencer: state, pc, load pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      wAddr_q     <= LOAD_BASE;
      word_q      <= '0;
      last_q      <= 1'b0;
      k_q         <= '0;
      ldReady_q   <= 1'b0;
      memAddr_q   <= '0;
      memWe_q     <= 1'b0;
      memWdata_q  <= '0;
      instValid_q <= 1'b0;
      inst_q      <= '0;
      instPc_q    <= '0;
      busy_q      <= 1'b0;
      loadDone_q  <= 1'b0;
      alignErr_q  <= 1'b0;
    end else begin
      loadDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_load) begin
            wAddr_q   <= LOAD_BASE;
            ldReady_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD_WAIT;
          end else if (bus.run) begin
            pc_q      <= RESET_PC;
            k_q       <= '0;
            memAddr_q <= RESET_PC[ADDR_W-1:0];
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end

        LOAD_WAIT: begin
          if (bus.ld_valid) begin
            word_q     <= bus.ld_data;
            last_q     <= bus.ld_last;
            k_q        <= '0;
            ldReady_q  <= 1'b0;
            memWe_q    <= 1'b1;
            memAddr_q  <= wAddr_q;
            memWdata_q <= bus.ld_data[31:24];
            state_q    <= LOAD_WR;
          end
        end

        LOAD_WR: begin
          if (k_q != 2'd3) begin
            k_q        <= kPlus1_d;
            memAddr_q  <= wrNextAddr_d;
            memWdata_q <= wrNextByte_d;
          end else begin
            memWe_q <= 1'b0;
            wAddr_q <= wAddr_q + ADDR_W'(4);
            k_q     <= '0;
            if (last_q) begin
              loadDone_q <= 1'b1;
              pc_q       <= RESET_PC;
              memAddr_q  <= RESET_PC[ADDR_W-1:0];
              state_q    <= FETCH;
            end else begin
              ldReady_q <= 1'b1;
              state_q   <= LOAD_WAIT;
            end
          end
        end

        FETCH, HOLD: begin
          if (bus.redir_valid) begin
            // A redirect discards whatever is partially assembled or held.
            instValid_q <= 1'b0;
            if (bus.redir_pc[1:0] == 2'b00) begin
              pc_q      <= bus.redir_pc;
              k_q       <= '0;
              memAddr_q <= bus.redir_pc[ADDR_W-1:0];
              state_q   <= FETCH;
            end else begin
              alignErr_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= ERR;
            end
          end else if (state_q == FETCH) begin
            case (k_q)
              2'd0:    inst_q[31:24] <= bus.mem_rdata;
              2'd1:    inst_q[23:16] <= bus.mem_rdata;
              2'd2:    inst_q[15:8]  <= bus.mem_rdata;
              default: inst_q[7:0]   <= bus.mem_rdata;
            endcase
            if (k_q == 2'd3) begin
              instValid_q <= 1'b1;
              instPc_q    <= pc_q;
              state_q     <= HOLD;
            end else begin
              k_q       <= kPlus1_d;
              memAddr_q <= fetchNextAddr_d;
            end
          end else if (bus.inst_ready) begin
            instValid_q <= 1'b0;
            pc_q        <= pcPlus4_d;
            k_q         <= '0;
            memAddr_q   <= pcPlus4_d[ADDR_W-1:0];
            state_q     <= FETCH;
          end
        end

        ERR: begin
          // Parked until reset; outputs keep their values.
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          memWe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ld_ready   = ldReady_q;
  assign bus.mem_addr   = memAddr_q;
  assign bus.mem_we     = memWe_q;
  assign bus.mem_wdata  = memWdata_q;
  assign bus.inst_valid = instValid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = instPc_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = loadDone_q;
  assign bus.align_err  = alignErr_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: models the byte memory, drives directed
// and randomized load/fetch/redirect traffic, and predicts instructions from
// a separately maintained reference image of the memory.
module tb_instr_fetch_ctrl;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic fillReq;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem    [0:65535];
  logic [7:0]  refMem [0:65535];
  logic [31:0] image  [$];

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000),
    .LOAD_BASE(16'h0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Initial memory contents, a fixed function of the address.
  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) ^ (i >> 8) ^ 32'h5A);
  endfunction

  // Byte memory: combinational read, write on rising edge.
  always @(posedge clk) begin
    if (fillReq) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  // Big-endian word at pc from the reference image, byte addresses wrap at 64 KiB.
  function automatic logic [31:0] refWord(input logic [31:0] pc);
    logic [15:0] a0, a1, a2, a3;
    a0 = pc[15:0];
    a1 = a0 + 16'd1;
    a2 = a0 + 16'd2;
    a3 = a0 + 16'd3;
    return {refMem[a0], refMem[a1], refMem[a2], refMem[a3]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sl, input logic rn, input logic lv,
                               input logic [31:0] ld, input logic ll, input logic ir,
                               input logic rv, input logic [31:0] rp);
    bus.start_load  = sl;
    bus.run         = rn;
    bus.ld_valid    = lv;
    bus.ld_data     = ld;
    bus.ld_last     = ll;
    bus.inst_ready  = ir;
    bus.redir_valid = rv;
    bus.redir_pc    = rp;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ld_ready"},   32'(bus.ld_ready),   32'd0);
    checkOutput({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    checkOutput({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    checkOutput({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
    checkOutput({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
    checkOutput({tag, "_inst"},       bus.inst,            32'd0);
    checkOutput({tag, "_inst_pc"},    bus.inst_pc,         32'd0);
    checkOutput({tag, "_busy"},       32'(bus.busy),       32'd0);
    checkOutput({tag, "_load_done"},  32'(bus.load_done),  32'd0);
    checkOutput({tag, "_align_err"},  32'(bus.align_err),  32'd0);
  endtask

  // Waits (bounded) for inst_valid with inputs idle; n returns the cycles waited.
  task automatic waitValid(input string tag, output int n);
    n = 0;
    while (!bus.inst_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
  endtask

  // Streams the image queue from LOAD_BASE (state must be LOAD_WAIT); checks
  // every byte write and updates the reference memory; ends on the load_done cycle.
  task automatic loadImage(input bit gaps);
    logic [15:0] a;
    logic [31:0] w;
    logic [7:0]  b;
    a = 16'h0000;
    for (int i = 0; i < image.size(); i++) begin
      int gap;
      gap = gaps ? int'($urandom_range(0, 3)) : 0;
      for (int g = 0; g < gap; g++) begin
        idleInputs();
        tick();
      end
      checkOutput("ld_ready_wait", 32'(bus.ld_ready), 32'd1);
      w = image[i];
      applyStimulus(1'b0, 1'b0, 1'b1, w, (i == image.size() - 1), 1'b0, 1'b0, 32'h0);
      tick();
      idleInputs();
      for (int k = 0; k < 4; k++) begin
        b = 8'(w >> (24 - 8 * k));
        checkOutput("ld_mem_we",    32'(bus.mem_we),    32'd1);
        checkOutput("ld_mem_addr",  32'(bus.mem_addr),  32'(a + 16'(k)));
        checkOutput("ld_mem_wdata", 32'(bus.mem_wdata), 32'(b));
        refMem[a + 16'(k)] = b;
        tick();
      end
      a = a + 16'd4;
      if (i == image.size() - 1) begin
        checkOutput("load_done_pulse", 32'(bus.load_done), 32'd1);
        checkOutput("load_fetch_addr", 32'(bus.mem_addr),  32'd0);
        checkOutput("load_ld_ready",   32'(bus.ld_ready),  32'd0);
      end else begin
        checkOutput("load_done_early", 32'(bus.load_done), 32'd0);
      end
    end
  endtask

  // Random ready/redirect traffic; the model tracks the pc of the in-flight instruction.
  task automatic randomFetch(input int cycles, input logic [31:0] startPc, input logic [15:0] tgtMask);
    logic [31:0] expPc;
    logic [31:0] tgt;
    logic        doRedir, rdy, wasValid;
    int          hs;
    expPc = startPc;
    hs    = 0;
    for (int c = 0; c < cycles; c++) begin
      doRedir  = ($urandom_range(0, 19) == 0);
      rdy      = 1'($urandom_range(0, 1));
      tgt      = {16'h0, 16'($urandom) & tgtMask};
      wasValid = bus.inst_valid;
      if (wasValid) begin
        checkOutput("rand_inst",    bus.inst,    refWord(expPc));
        checkOutput("rand_inst_pc", bus.inst_pc, expPc);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, rdy, doRedir, tgt);
      tick();
      if (doRedir) expPc = tgt;
      else if (wasValid && rdy) begin
        expPc = expPc + 32'd4;
        hs++;
      end
    end
    idleInputs();
    checkOutput("rand_progress", 32'(hs > 0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] expBytes;
    logic [31:0] prevInst, prevPc, w;
    logic [15:0] heldAddr;
    int          n;

    for (int i = 0; i < 65536; i++) refMem[i] = pat(i);
    rst_n   = 1'b0;
    fillReq = 1'b1;
    idleInputs();
    tick();
    fillReq = 1'b0;
    tick();
    checkAllZero("reset");
    rst_n = 1'b1;

    // Directed load of the two-word image, then fetch.
    image = '{32'h2008_0005, 32'h2109_0003};
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idleInputs();
    loadImage(1'b0);
    expBytes = 64'h2008_0005_2109_0003;
    for (int i = 0; i < 8; i++)
      checkOutput("load_bytes", 32'(mem[i]), 32'(expBytes[63 - 8 * i -: 8]));
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("fetch0_addr", 32'(bus.mem_addr), 32'(k));
      checkOutput("load_done_once", 32'(bus.load_done), 32'd0);
    end
    tick();
    checkOutput("inst0_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("inst0",       bus.inst,            32'h2008_0005);
    checkOutput("inst0_pc",    bus.inst_pc,         32'h0);
    bus.inst_ready = 1'b1;
    tick();
    idleInputs();
    checkOutput("inst0_accept_valid", 32'(bus.inst_valid), 32'd0);
    waitValid("inst1", n);
    checkOutput("inst1",    bus.inst,    32'h2109_0003);
    checkOutput("inst1_pc", bus.inst_pc, 32'h4);

    // Backpressure: seven cycles without inst_ready.
    prevInst = bus.inst;
    prevPc   = bus.inst_pc;
    heldAddr = bus.mem_addr;
    for (int c = 0; c < 7; c++) begin
      tick();
      checkOutput("bp_valid",   32'(bus.inst_valid), 32'd1);
      checkOutput("bp_inst",    bus.inst,            prevInst);
      checkOutput("bp_pc",      bus.inst_pc,         prevPc);
      checkOutput("bp_addr",    32'(bus.mem_addr),   32'(heldAddr));
    end
    bus.inst_ready = 1'b1;
    tick();
    idleInputs();
    checkOutput("bp_accept_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("bp_next_addr",    32'(bus.mem_addr),   32'h8);

    // Redirect to 0x40 while at fetch byte 2 of the instruction at 8.
    tick();
    tick();
    checkOutput("pre_redir_addr", 32'(bus.mem_addr), 32'hA);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    tick();
    idleInputs();
    checkOutput("redir_addr0", 32'(bus.mem_addr),   32'h40);
    checkOutput("redir_valid", 32'(bus.inst_valid), 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("redir_addr", 32'(bus.mem_addr), 32'h40 + 32'(k));
    end
    tick();
    checkOutput("redir_inst_valid", 32'(bus.inst_valid), 32'd1);
    checkOutput("redir_inst_pc",    bus.inst_pc,         32'h40);
    checkOutput("redir_inst",       bus.inst,            refWord(32'h40));

    // Accept and redirect in the same cycle: redirect target wins.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0010);
    tick();
    idleInputs();
    checkOutput("both_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("both_addr",  32'(bus.mem_addr),   32'h10);
    waitValid("both", n);
    checkOutput("both_latency", 32'(n),      32'd4);
    checkOutput("both_inst_pc", bus.inst_pc, 32'h10);
    checkOutput("both_inst",    bus.inst,    refWord(32'h10));
    bus.inst_ready = 1'b1;
    tick();
    idleInputs();

    // Randomized ready/redirect traffic over the whole address space.
    randomFetch(300, 32'h14, 16'hFFFC);

    // Wrap of the byte address at the top of memory.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_FFFC);
    tick();
    idleInputs();
    checkOutput("wrap_addr0", 32'(bus.mem_addr), 32'hFFFC);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("wrap_addr", 32'(bus.mem_addr), 32'hFFFC + 32'(k));
    end
    tick();
    checkOutput("wrap_inst_pc", bus.inst_pc, 32'h0000_FFFC);
    checkOutput("wrap_inst",    bus.inst,    refWord(32'h0000_FFFC));
    bus.inst_ready = 1'b1;
    tick();
    idleInputs();
    checkOutput("wrap_next_addr", 32'(bus.mem_addr), 32'h0);
    waitValid("wrap_next", n);
    checkOutput("wrap_next_pc",   bus.inst_pc, 32'h0001_0000);
    checkOutput("wrap_next_inst", bus.inst,    refWord(32'h0001_0000));

    // Misaligned redirect parks the controller in the error state.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0006);
    tick();
    idleInputs();
    checkOutput("err_align", 32'(bus.align_err),  32'd1);
    checkOutput("err_valid", 32'(bus.inst_valid), 32'd0);
    checkOutput("err_busy",  32'(bus.busy),       32'd0);
    heldAddr = bus.mem_addr;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom),
                    1'($urandom), 1'($urandom), $urandom & 32'hFFFC);
      tick();
      checkOutput("err_sticky",   32'(bus.align_err), 32'd1);
      checkOutput("err_mem_we",   32'(bus.mem_we),    32'd0);
      checkOutput("err_mem_addr", 32'(bus.mem_addr),  32'(heldAddr));
      checkOutput("err_ld_ready", 32'(bus.ld_ready),  32'd0);
      checkOutput("err_busy_hi",  32'(bus.busy),      32'd0);
    end
    idleInputs();
    rst_n = 1'b0;
    tick();
    checkAllZero("err_reset");
    rst_n = 1'b1;

    // Run without loading: fetch from RESET_PC.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idleInputs();
    checkOutput("run_busy", 32'(bus.busy),     32'd1);
    checkOutput("run_addr", 32'(bus.mem_addr), 32'h0);
    waitValid("run", n);
    checkOutput("run_inst_pc", bus.inst_pc, 32'h0);
    checkOutput("run_inst",    bus.inst,    refWord(32'h0));

    // Reset in the middle of a load word leaves it half written.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("ml_ld_ready", 32'(bus.ld_ready), 32'd1);
    w = $urandom;
    applyStimulus(1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("ml_k1_addr", 32'(bus.mem_addr), 32'h1);
    rst_n = 1'b0;
    tick();
    checkAllZero("midload_reset");
    rst_n = 1'b1;
    refMem[0] = w[31:24];
    refMem[1] = w[23:16];
    for (int i = 0; i < 4; i++)
      checkOutput("ml_partial_bytes", 32'(mem[i]), 32'(refMem[i]));

    // start_load wins over run; random image with random loader gaps.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    idleInputs();
    checkOutput("prio_ld_ready", 32'(bus.ld_ready), 32'd1);
    checkOutput("prio_busy",     32'(bus.busy),     32'd1);
    image = {};
    for (int i = 0; i < 5; i++) image.push_back($urandom);
    loadImage(1'b1);
    for (int i = 0; i < 20; i++)
      checkOutput("rload_bytes", 32'(mem[i]), 32'(refMem[i]));
    randomFetch(150, 32'h0, 16'h001C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
